// File: rtl/acp_slave_mem.sv
// acp_slave_mem: AXI3-subset INCR burst responder over an internal word memory.
// Define ACP_SLV_STALL_EN to add LFSR-driven ready/valid stalls.
module acp_slave_mem #(
  parameter int ACP_WIDTH = 64,
  parameter int ADDR_WIDTH = 32,
  parameter int MEM_DEPTH = 4096,
  parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
  input  logic                  CLK,
  input  logic                  RST_N,
  input  logic                  arvalid,
  input  logic [ADDR_WIDTH-1:0] araddr,
  input  logic [3:0]            arlen,
  output logic                  arready,
  output logic                  rvalid,
  output logic [ACP_WIDTH-1:0]  rdata,
  output logic                  rlast,
  input  logic                  rready,
  input  logic                  awvalid,
  input  logic [ADDR_WIDTH-1:0] awaddr,
  input  logic [3:0]            awlen,
  output logic                  awready,
  input  logic                  wvalid,
  input  logic [ACP_WIDTH-1:0]  wdata,
  input  logic                  wlast,
  output logic                  wready,
  output logic                  bvalid,
  output logic                  proto_err
);
  localparam int IW = $clog2(MEM_DEPTH);
  localparam int OFF = $clog2(ACP_WIDTH / 8);
  typedef enum logic {R_IDLE, R_DATA} r_state_e;
  typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_e;
  logic [ACP_WIDTH-1:0] mem_q [MEM_DEPTH];
  r_state_e rs_q, rs_d;
  w_state_e ws_q, ws_d;
  logic [IW-1:0] ridx_q, ridx_d, widx_q, widx_d;
  logic [3:0] rlen_q, rlen_d, rbeat_q, rbeat_d, wlen_q, wlen_d, wbeat_q, wbeat_d;
  logic arready_d, rvalid_d, rlast_d, awready_d, wready_d, bvalid_d, proto_err_d;
  logic [ACP_WIDTH-1:0] rdata_d;
  logic ar_hs, r_hs, aw_hs, w_hs, w_end, stall_d;
  logic unused_cfg;
  assign unused_cfg = ^{araddr, awaddr, LFSR_SEED};
`ifdef ACP_SLV_STALL_EN
  logic [15:0] lfsr_q, lfsr_d;
  assign lfsr_d = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
  // readies are registered, so the stall decision looks at the LFSR value of the coming cycle
  assign stall_d = lfsr_d[1:0] == 2'b00;
  always_ff @(posedge CLK or negedge RST_N)
    if (!RST_N) lfsr_q <= LFSR_SEED;
    else lfsr_q <= lfsr_d;
`else
  assign stall_d = 1'b0;
`endif
  always_comb begin
    ar_hs = arvalid & arready;
    r_hs = rvalid & rready;
    rs_d = rs_q;
    ridx_d = ridx_q;
    rlen_d = rlen_q;
    rbeat_d = rbeat_q;
    if (ar_hs) begin
      rs_d = R_DATA;
      ridx_d = araddr[OFF +: IW];
      rlen_d = arlen;
      rbeat_d = '0;
    end else if (r_hs && rlast) rs_d = R_IDLE;
    else if (r_hs) begin
      ridx_d = ridx_q + IW'(1);
      rbeat_d = rbeat_q + 4'd1;
    end
    arready_d = (rs_d == R_IDLE) & ~stall_d;
    // an rvalid already up is held until its handshake
    rvalid_d = (rs_d == R_DATA) & (rvalid | ~stall_d);
    rlast_d = rvalid_d & (rbeat_d == rlen_d);
    rdata_d = (rs_d == R_DATA) ? mem_q[ridx_d] : rdata;
  end
  always_comb begin
    aw_hs = awvalid & awready;
    w_hs = wvalid & wready;
    w_end = wbeat_q == wlen_q;
    ws_d = ws_q;
    widx_d = widx_q;
    wlen_d = wlen_q;
    wbeat_d = wbeat_q;
    if (aw_hs) begin
      ws_d = W_DATA;
      widx_d = awaddr[OFF +: IW];
      wlen_d = awlen;
      wbeat_d = '0;
    end else if (w_hs) begin
      widx_d = widx_q + IW'(1);
      wbeat_d = wbeat_q + 4'd1;
      ws_d = w_end ? W_RESP : W_DATA;
    end else if (ws_q == W_RESP) ws_d = W_IDLE;
    awready_d = (ws_d == W_IDLE) & ~stall_d;
    wready_d = (ws_d == W_DATA) & ~stall_d;
    bvalid_d = ws_d == W_RESP;
    proto_err_d = proto_err | (w_hs & (wlast != w_end));
  end
  always_ff @(posedge CLK)
    if (w_hs) mem_q[widx_q] <= wdata;
  always_ff @(posedge CLK or negedge RST_N)
    if (!RST_N) begin
      rs_q <= R_IDLE;
      ws_q <= W_IDLE;
      ridx_q <= '0;
      widx_q <= '0;
      rlen_q <= '0;
      rbeat_q <= '0;
      wlen_q <= '0;
      wbeat_q <= '0;
      arready <= 1'b0;
      rvalid <= 1'b0;
      rlast <= 1'b0;
      rdata <= '0;
      awready <= 1'b0;
      wready <= 1'b0;
      bvalid <= 1'b0;
      proto_err <= 1'b0;
    end else begin
      rs_q <= rs_d;
      ws_q <= ws_d;
      ridx_q <= ridx_d;
      widx_q <= widx_d;
      rlen_q <= rlen_d;
      rbeat_q <= rbeat_d;
      wlen_q <= wlen_d;
      wbeat_q <= wbeat_d;
      arready <= arready_d;
      rvalid <= rvalid_d;
      rlast <= rlast_d;
      rdata <= rdata_d;
      awready <= awready_d;
      wready <= wready_d;
      bvalid <= bvalid_d;
      proto_err <= proto_err_d;
    end
endmodule

// File: tb/tb_acp_slave_mem.sv
// tb_acp_slave_mem: randomized bursts against an array memory model of acp_slave_mem.
module tb_acp_slave_mem;
  logic CLK = 1'b0, RST_N = 1'b0;
  logic arvalid = 1'b0, rready = 1'b0, awvalid = 1'b0, wvalid = 1'b0, wlast = 1'b0;
  logic [31:0] araddr = '0, awaddr = '0;
  logic [3:0] arlen = '0, awlen = '0;
  logic [63:0] wdata = '0, rdata;
  logic arready, rvalid, rlast, awready, wready, bvalid, proto_err;
  int vecs = 0, errs = 0;
  logic [63:0] model [4096];
  logic [63:0] wd [16];
  logic [63:0] rd_q [$];
  bit rl_q [$];

  always #5 CLK = ~CLK;

  acp_slave_mem dut (
    .CLK(CLK), .RST_N(RST_N),
    .arvalid(arvalid), .araddr(araddr), .arlen(arlen), .arready(arready),
    .rvalid(rvalid), .rdata(rdata), .rlast(rlast), .rready(rready),
    .awvalid(awvalid), .awaddr(awaddr), .awlen(awlen), .awready(awready),
    .wvalid(wvalid), .wdata(wdata), .wlast(wlast), .wready(wready),
    .bvalid(bvalid), .proto_err(proto_err)
  );

  function automatic int widx(input logic [31:0] a, input int b);
    return (int'(a >> 3) + b) % 4096;
  endfunction

  task automatic write_burst(input logic [31:0] a, input int len, input int lastbeat,
                             output bit to, output bit b_l, output bit wr_l, output bit b_n, output bit aw_n);
    int t;
    to = 0;
    @(negedge CLK);
    awvalid = 1'b1; awaddr = a; awlen = 4'(len);
    t = 0;
    while (!awready && t < 100) begin @(negedge CLK); t++; end
    if (t == 100) to = 1;
    for (int b = 0; b <= len; b++) begin
      @(negedge CLK);
      awvalid = 1'b0; wvalid = 1'b1; wdata = wd[b]; wlast = (b == lastbeat);
      t = 0;
      while (!wready && t < 100) begin @(negedge CLK); t++; end
      if (t == 100) to = 1;
      model[widx(a, b)] = wd[b];
    end
    @(negedge CLK);
    wvalid = 1'b0; wlast = 1'b0; b_l = bvalid; wr_l = wready;
    @(negedge CLK);
    b_n = bvalid; aw_n = awready;
  endtask

  task automatic read_burst(input logic [31:0] a, input int len, input int mode,
                            output bit to, output int hb, output bit rv_f, output bit ar_f,
                            output bit rv_n, output bit ar_n);
    int t, got, cyc;
    logic [63:0] pd;
    bit pl, pend;
    rd_q.delete(); rl_q.delete();
    to = 0; hb = 0; pend = 0; pd = '0; pl = 0;
    @(negedge CLK);
    arvalid = 1'b1; araddr = a; arlen = 4'(len);
    t = 0;
    while (!arready && t < 100) begin @(negedge CLK); t++; end
    if (t == 100) to = 1;
    @(negedge CLK);
    arvalid = 1'b0; rv_f = rvalid; ar_f = arready;
    got = 0; cyc = 0;
    while (got <= len && cyc < 300) begin
      rready = (mode == 0) ? 1'b1 : (mode == 1) ? ((cyc % 4 == 0) || (cyc % 4 == 3)) : 1'($urandom_range(0, 1));
      if (pend && (!rvalid || rdata !== pd || rlast !== pl)) hb++;
      pend = 0;
      if (rvalid && rready) begin rd_q.push_back(rdata); rl_q.push_back(rlast); got++; end
      else if (rvalid) begin pend = 1; pd = rdata; pl = rlast; end
      cyc++;
      @(negedge CLK);
    end
    if (got <= len) to = 1;
    rready = 1'b0; rv_n = rvalid; ar_n = arready;
  endtask

  task automatic test_reset();
    repeat (3) @(negedge CLK);
    vecs++;
    if ({arready, awready, rvalid, rlast, wready, bvalid, proto_err} !== 7'b0 || rdata !== 64'h0) begin
      errs++; $display("FAIL reset_vals: outs=%b rdata=%h, want all 0", {arready, awready, rvalid, rlast, wready, bvalid, proto_err}, rdata);
    end
    RST_N = 1'b1;
    #1;
    vecs++;
    if ({arready, awready} !== 2'b00) begin errs++; $display("FAIL reset_release_early: ar/aw=%b want 00", {arready, awready}); end
    @(negedge CLK);
    vecs++;
    if ({arready, awready} !== 2'b11) begin errs++; $display("FAIL reset_release: ar/aw=%b want 11", {arready, awready}); end
  endtask

  task automatic test_write_burst();
    bit to, b_l, wr_l, b_n, aw_n;
    for (int i = 0; i < 16; i++) wd[i] = 64'(i);
    write_burst(32'h100, 15, 15, to, b_l, wr_l, b_n, aw_n);
    vecs++;
    if ({to, b_l, wr_l, b_n, aw_n, proto_err} !== 6'b010010) begin
      errs++; $display("FAIL write_burst: to/bL/wrL/bN/awN/perr=%b want 010010", {to, b_l, wr_l, b_n, aw_n, proto_err});
    end
  endtask

  task automatic test_read_burst();
    bit to, rv_f, ar_f, rv_n, ar_n;
    int hb;
    read_burst(32'h100, 15, 0, to, hb, rv_f, ar_f, rv_n, ar_n);
    vecs++;
    if (to || rd_q.size() != 16) begin errs++; $display("FAIL read_count: beats=%0d to=%0d want 16", rd_q.size(), to); end
    for (int i = 0; i < rd_q.size(); i++) begin
      vecs++;
      if (rd_q[i] !== 64'(i) || rl_q[i] != (i == 15)) begin
        errs++; $display("FAIL read_beat%0d: data=%h last=%0d want %h last=%0d", i, rd_q[i], rl_q[i], 64'(i), i == 15);
      end
    end
    vecs++;
    if ({rv_f, ar_f, rv_n, ar_n} !== 4'b1001) begin errs++; $display("FAIL read_timing: rvF/arF/rvN/arN=%b want 1001", {rv_f, ar_f, rv_n, ar_n}); end
  endtask

  task automatic test_wrap();
    bit to, b_l, wr_l, b_n, aw_n, rv_f, ar_f, rv_n, ar_n;
    int hb;
    for (int i = 0; i < 4; i++) wd[i] = {$urandom, $urandom};
    write_burst(32'h7FF0, 3, 3, to, b_l, wr_l, b_n, aw_n);
    vecs++;
    if ({to, b_l} !== 2'b01) begin errs++; $display("FAIL wrap_write: to/bL=%b want 01", {to, b_l}); end
    read_burst(32'h0, 1, 0, to, hb, rv_f, ar_f, rv_n, ar_n);
    for (int i = 0; i < 2; i++) begin
      vecs++;
      if (rd_q.size() != 2 || rd_q[i] !== wd[2 + i]) begin errs++; $display("FAIL wrap_word%0d: got %h want %h", i, rd_q.size() == 2 ? rd_q[i] : 64'hx, wd[2 + i]); end
    end
    read_burst(32'h7FF5, 3, 0, to, hb, rv_f, ar_f, rv_n, ar_n);
    for (int i = 0; i < 4; i++) begin
      vecs++;
      if (rd_q.size() != 4 || rd_q[i] !== wd[i] || rl_q[i] != (i == 3)) begin
        errs++; $display("FAIL wrap_read%0d: got %h want %h", i, rd_q.size() == 4 ? rd_q[i] : 64'hx, wd[i]);
      end
    end
  endtask

  task automatic test_stall();
    bit to, b_l, wr_l, b_n, aw_n, rv_f, ar_f, rv_n, ar_n;
    int hb;
    for (int i = 0; i < 4; i++) wd[i] = {$urandom, $urandom};
    write_burst(32'h2000, 3, 3, to, b_l, wr_l, b_n, aw_n);
    read_burst(32'h2000, 3, 1, to, hb, rv_f, ar_f, rv_n, ar_n);
    vecs++;
    if (to || hb != 0 || rd_q.size() != 4) begin errs++; $display("FAIL stall_hold: holdviol=%0d beats=%0d to=%0d want 0/4/0", hb, rd_q.size(), to); end
    for (int i = 0; i < rd_q.size(); i++) begin
      vecs++;
      if (rd_q[i] !== model[widx(32'h2000, i)] || rl_q[i] != (i == 3)) begin
        errs++; $display("FAIL stall_beat%0d: got %h last=%0d want %h", i, rd_q[i], rl_q[i], model[widx(32'h2000, i)]);
      end
    end
  endtask

  task automatic test_proto_err();
    bit to, b_l, wr_l, b_n, aw_n, rv_f, ar_f, rv_n, ar_n;
    int hb;
    vecs++;
    if (proto_err !== 1'b0) begin errs++; $display("FAIL perr_pre: got %b want 0", proto_err); end
    for (int i = 0; i < 4; i++) wd[i] = {$urandom, $urandom};
    write_burst(32'h3000, 3, 2, to, b_l, wr_l, b_n, aw_n);
    vecs++;
    if ({to, b_l, b_n, proto_err} !== 4'b0101) begin errs++; $display("FAIL perr_burst: to/bL/bN/perr=%b want 0101", {to, b_l, b_n, proto_err}); end
    wd[0] = {$urandom, $urandom};
    write_burst(32'h3100, 0, 0, to, b_l, wr_l, b_n, aw_n);
    vecs++;
    if ({b_l, proto_err} !== 2'b11) begin errs++; $display("FAIL perr_sticky: bL/perr=%b want 11", {b_l, proto_err}); end
    read_burst(32'h3000, 3, 0, to, hb, rv_f, ar_f, rv_n, ar_n);
    for (int i = 0; i < rd_q.size(); i++) begin
      vecs++;
      if (rd_q[i] !== model[widx(32'h3000, i)]) begin errs++; $display("FAIL perr_read%0d: got %h want %h", i, rd_q[i], model[widx(32'h3000, i)]); end
    end
  endtask

  task automatic test_random();
    bit to, b_l, wr_l, b_n, aw_n, rv_f, ar_f, rv_n, ar_n;
    int hb, len;
    logic [31:0] a;
    for (int k = 0; k < 10; k++) begin
      a = 32'((2048 + $urandom_range(0, 999)) * 8 + $urandom_range(0, 7));
      len = $urandom_range(0, 15);
      for (int i = 0; i < 16; i++) wd[i] = {$urandom, $urandom};
      write_burst(a, len, len, to, b_l, wr_l, b_n, aw_n);
      vecs++;
      if ({to, b_l, wr_l, b_n, aw_n} !== 5'b01001) begin errs++; $display("FAIL rand_write%0d: to/bL/wrL/bN/awN=%b want 01001", k, {to, b_l, wr_l, b_n, aw_n}); end
      read_burst(a, len, 2, to, hb, rv_f, ar_f, rv_n, ar_n);
      vecs++;
      if (to || hb != 0 || rd_q.size() != len + 1) begin errs++; $display("FAIL rand_count%0d: beats=%0d hold=%0d want %0d", k, rd_q.size(), hb, len + 1); end
      for (int i = 0; i < rd_q.size(); i++) begin
        vecs++;
        if (rd_q[i] !== model[widx(a, i)] || rl_q[i] != (i == len)) begin
          errs++; $display("FAIL rand_beat%0d_%0d: got %h last=%0d want %h", k, i, rd_q[i], rl_q[i], model[widx(a, i)]);
        end
      end
    end
  endtask

  task automatic test_back_to_back();
    bit to, b_l, wr_l, b_n, aw_n, wto, rv_f, ar_f, rv_n, ar_n;
    int hb;
    for (int i = 0; i < 8; i++) wd[i] = {$urandom, $urandom};
    fork
      write_burst(32'h6D60, 7, 7, wto, b_l, wr_l, b_n, aw_n);
      read_burst(32'h100, 15, 2, to, hb, rv_f, ar_f, rv_n, ar_n);
    join
    vecs++;
    if ({wto, to, b_l} !== 3'b001 || hb != 0) begin errs++; $display("FAIL conc_status: wto/rto/bL=%b hold=%0d want 001/0", {wto, to, b_l}, hb); end
    for (int i = 0; i < rd_q.size(); i++) begin
      vecs++;
      if (rd_q[i] !== model[widx(32'h100, i)]) begin errs++; $display("FAIL conc_read%0d: got %h want %h", i, rd_q[i], model[widx(32'h100, i)]); end
    end
    read_burst(32'h6D60, 7, 0, to, hb, rv_f, ar_f, rv_n, ar_n);
    for (int i = 0; i < rd_q.size(); i++) begin
      vecs++;
      if (rd_q[i] !== wd[i]) begin errs++; $display("FAIL conc_back%0d: got %h want %h", i, rd_q[i], wd[i]); end
    end
  endtask

  task automatic test_reset_mid_burst();
    bit to, rv_f, ar_f, rv_n, ar_n;
    int hb, t, got;
    @(negedge CLK);
    arvalid = 1'b1; araddr = 32'h100; arlen = 4'd15;
    t = 0;
    while (!arready && t < 100) begin @(negedge CLK); t++; end
    @(negedge CLK);
    arvalid = 1'b0; rready = 1'b1; got = 0; t = 0;
    while (got < 6 && t < 100) begin
      if (rvalid) begin
        vecs++;
        if (rdata !== model[widx(32'h100, got)]) begin errs++; $display("FAIL mid_beat%0d: got %h want %h", got, rdata, model[widx(32'h100, got)]); end
        got++;
      end
      t++;
      @(negedge CLK);
    end
    RST_N = 1'b0;
    #1;
    vecs++;
    if ({got == 6, rvalid, arready, rlast, proto_err} !== 5'b10000 || rdata !== 64'h0) begin
      errs++; $display("FAIL mid_reset: got6/rv/ar/rlast/perr=%b rdata=%h want 10000/0", {got == 6, rvalid, arready, rlast, proto_err}, rdata);
    end
    rready = 1'b0;
    @(negedge CLK);
    RST_N = 1'b1;
    @(negedge CLK);
    vecs++;
    if ({arready, awready, rvalid} !== 3'b110) begin errs++; $display("FAIL mid_release: ar/aw/rv=%b want 110", {arready, awready, rvalid}); end
    read_burst(32'h100, 15, 0, to, hb, rv_f, ar_f, rv_n, ar_n);
    vecs++;
    if (to || rd_q.size() != 16) begin errs++; $display("FAIL mid_after_count: beats=%0d want 16", rd_q.size()); end
    for (int i = 0; i < rd_q.size(); i++) begin
      vecs++;
      if (rd_q[i] !== model[widx(32'h100, i)] || rl_q[i] != (i == 15)) begin
        errs++; $display("FAIL mid_after%0d: got %h want %h", i, rd_q[i], model[widx(32'h100, i)]);
      end
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_write_burst();
    test_read_burst();
    test_wrap();
    test_stall();
    test_proto_err();
    test_random();
    test_back_to_back();
    test_reset_mid_burst();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule

// File: doc/acp_slave_mem.md
# acp_slave_mem

Simulation and FPGA-side AXI3-subset responder that terminates the ACP master's read and write bursts against an internal word-addressed memory. It accepts INCR bursts of 1–16 beats on independent read and write channels, returns read data with `rlast`, stores write beats, and issues a single-cycle `bvalid` per write burst. It sits opposite the accelerator's ACP master in loopback benches and in PL-only test builds, where no PS7 port is present.

## Interface
Parameters:
- `ACP_WIDTH`, 64 — data beat width in bits; must be a power of two, at least 8.
- `ADDR_WIDTH`, 32 — byte-address width.
- `MEM_DEPTH`, 4096 — number of words; must be a power of two.
- `LFSR_SEED`, 16'hACE1 — stall LFSR seed; used only with the macro; must be non-zero.

Ports (one clock; reset is asynchronous and active-low):
- `CLK` in 1 — clock.
- `RST_N` in 1 — asynchronous active-low reset.
- `arvalid` in 1, `araddr` in ADDR_WIDTH, `arlen` in 4 — read address channel; `arlen` = beats − 1.
- `arready` out 1 — read address accept.
- `rvalid` out 1, `rdata` out ACP_WIDTH, `rlast` out 1 — read data channel.
- `rready` in 1 — read data accept.
- `awvalid` in 1, `awaddr` in ADDR_WIDTH, `awlen` in 4 — write address channel.
- `awready` out 1 — write address accept.
- `wvalid` in 1, `wdata` in ACP_WIDTH, `wlast` in 1 — write data channel.
- `wready` out 1 — write data accept.
- `bvalid` out 1 — write response, single-cycle pulse; there is no `bready`.
- `proto_err` out 1 — sticky: `wlast` did not match the expected final beat.

## Operation
- Word index = `addr >> log2(ACP_WIDTH/8)`, taken modulo `MEM_DEPTH`.
  - The index increments by 1 per beat.
  - It wraps from `MEM_DEPTH−1` to 0.
  - Low address bits are ignored.
- Memory contents are not reset.
- Read FSM:
  - R_IDLE: `arready`=1. On `arvalid&arready`, latch the index and `arlen`, clear the beat counter, and move to R_DATA.
  - R_DATA: `rvalid`=1, `rdata`=mem[idx], `rlast`=(beat==len).
  - On `rvalid&rready`: if not the last beat, increment idx and beat; if the last beat, go to R_IDLE.
- Write FSM:
  - W_IDLE: `awready`=1. On `awvalid&awready`, latch the index and `awlen`, clear the beat counter, and move to W_DATA.
  - W_DATA: `wready`=1. Each `wvalid&wready` writes `wdata` to mem[idx], then increments idx and beat.
  - On the beat where beat==len, move to W_RESP.
  - `wlast` high on any other beat, or low on this beat, sets `proto_err`; the burst still completes at len+1 beats.
  - W_RESP: `bvalid`=1 for exactly one cycle, then W_IDLE.
- `wvalid` outside W_DATA and `rready` outside R_DATA are ignored.
- The read and write channels are fully independent and may be active concurrently.
- Same-word read and write in one cycle: `rdata` presents the pre-write value; the new value is visible from the next read.

## Timing
- All outputs are registered.
- Reset values: `arready`=0, `awready`=0, `rvalid`=0, `rlast`=0, `rdata`=0, `wready`=0, `bvalid`=0, `proto_err`=0. Both FSMs reset to idle.
- `arready` and `awready` go to 1 at the first `CLK` edge after `RST_N` deasserts.
- Read timing (AR handshake at edge E):
  - `arready`=0 and `rvalid`=1 with beat 0 from E.
  - With `rready` held high, one beat per cycle.
  - After the last-beat edge, `rvalid`=0 and `arready`=1, giving a 1-cycle minimum gap between bursts.
- Write timing (AW handshake at edge E):
  - `wready`=1 from E.
  - Last beat accepted at edge L: `wready`=0 and `bvalid`=1 during L..L+1.
  - `awready`=1 from L+1.
- `RST_N` asserted mid-burst: all outputs go to their reset values immediately. The partial burst is abandoned and writes already accepted remain in memory.

## Configuration
- `ACP_SLV_STALL_EN` defined:
  - A 16-bit Fibonacci LFSR (taps 16,14,13,11) is seeded with `LFSR_SEED` at reset and advances every cycle.
  - When `lfsr[1:0]==0`, the following are forced to 0 that cycle: `arready`, `awready`, `wready`, and the *next* assertion of `rvalid`.
  - A `rvalid` that is already high is never dropped before its handshake.
- `ACP_SLV_STALL_EN` undefined: no LFSR is present; readies behave exactly as described in Operation.

## Test plan
- Write burst: `awaddr`=0x100, `awlen`=15, 16 beats of data 0..15 with `wlast` on beat 15 → `bvalid` one cycle after the last-beat edge, `proto_err`=0.
- Read burst: `araddr`=0x100, `arlen`=15, `rready`=1 → 16 consecutive `rvalid` cycles with data 0..15 and `rlast` only on beat 15; `arready` returns 1 the cycle after.
- Wrap: `MEM_DEPTH`=4096, `ACP_WIDTH`=64, write 4 beats at 0x7FF0 → words 4094, 4095, 0, 1 written; a read-back matches.
- Stall: `rready` toggled 1,0,0,1 during a 4-beat read → `rdata` and `rlast` hold during the low cycles and no beat is lost.
- Protocol error: `wlast` asserted on beat 2 of `awlen`=3 → the burst completes after 4 beats, `bvalid` pulses, and `proto_err` stays 1 until reset.
- Reset mid-burst: `RST_N`=0 after beat 5 of a 16-beat read → `rvalid`=0 at once; after release, `arready`=1 and a new burst is served correctly.
